cla_seq_adder: RTL and testbench

//  Multi-cycle sequencer that adds OP_WIDTH-bit operands on one shared SLICE_WIDTH-bit cla_adder.

---
 rtl/cla_seq_pkg.sv | 28 ++
 rtl/cla_seq_adder_cla.sv | 62 ++++++
 rtl/cla_seq_adder.sv | 148 ++++++++++++++
 tb/tb_cla_seq_adder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// ---------------------------------------------------------------------------
// cla_seq_pkg
//   Shared types and helpers for the sliced sequential adder.
//   - cla_seq_state_t : sequencer FSM state encoding (IDLE, RUN, DONE)
//   - clog2()         : ceiling log2, used to size the slice index register
// ---------------------------------------------------------------------------
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_seq_state_t;

    // Ceiling log2; clog2(1) == 0, so callers must clamp to a minimum width of 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage : cla_seq_pkg

// File: rtl/cla_seq_adder_cla.sv
// ---------------------------------------------------------------------------
// cla_adder
//   Combinational WIDTH-bit adder built from BLOCK_SIZE-bit carry-lookahead
//   groups. Inside a group every carry is computed in expanded
//   generate/propagate form from the group carry-in; group carry-outs are
//   chained between groups.
// Ports
//   a, b  in  WIDTH  addends
//   cin   in  1      carry into bit 0
//   sum   out WIDTH  a + b + cin (low WIDTH bits)
//   cout  out 1      carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module cla_adder #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NUM_BLOCKS = WIDTH / BLOCK_SIZE;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   carry;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic cj;
        logic pp;
        carry    = '0;
        carry[0] = cin;
        cj       = 1'b0;
        pp       = 1'b0;
        for (int unsigned blk = 0; blk < NUM_BLOCKS; blk++) begin
            for (int unsigned j = 1; j <= BLOCK_SIZE; j++) begin
                // c[base+j] = P[base..base+j-1]&c[base] | OR_k G[base+k]&P[base+k+1..base+j-1]
                cj = carry[blk*BLOCK_SIZE];
                for (int unsigned k = 0; k < j; k++) begin
                    cj = cj & p[blk*BLOCK_SIZE + k];
                end
                for (int unsigned k = 0; k < j; k++) begin
                    pp = g[blk*BLOCK_SIZE + k];
                    for (int unsigned m = k + 1; m < j; m++) begin
                        pp = pp & p[blk*BLOCK_SIZE + m];
                    end
                    cj = cj | pp;
                end
                carry[blk*BLOCK_SIZE + j] = cj;
            end
        end
    end

    assign sum  = p ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];

endmodule : cla_adder

// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder
//   Adds two OP_WIDTH-bit operands over NUM_SLICES cycles on one shared
//   SLICE_WIDTH-bit cla_adder, LSB slice first, carrying each slice's
//   carry-out into the next. Valid/ready on both the request and result side.
//   Optional feature macro: CLA_SEQ_SUB_EN adds in_sub (A - B, cout = no borrow).
// Ports
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         operand request
//   in_ready   out  1         high only in IDLE
//   in_a/in_b  in   OP_WIDTH  operands, captured at accept
//   in_cin     in   1         carry-in to slice 0
//   in_sub     in   1         subtract select (CLA_SEQ_SUB_EN only)
//   out_valid  out  1         result available (DONE)
//   out_ready  in   1         consumer accepts the result
//   out_sum    out  OP_WIDTH  result, held until overwritten by the next op
//   out_cout   out  1         carry-out of the top slice
//   busy       out  1         high in RUN or DONE
// ---------------------------------------------------------------------------
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int unsigned OP_WIDTH    = 128,
    parameter int unsigned SLICE_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] in_a,
    input  logic [OP_WIDTH-1:0] in_b,
    input  logic                in_cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                in_sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_WIDTH-1:0] out_sum,
    output logic                out_cout,
    output logic                busy
);

    localparam int unsigned NUM_SLICES = OP_WIDTH / SLICE_WIDTH;
    localparam int unsigned IDX_W      = (clog2(NUM_SLICES) < 1) ? 1 : clog2(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    if ((SLICE_WIDTH == 0) || (OP_WIDTH % SLICE_WIDTH != 0) ||
        (SLICE_WIDTH % 4 != 0) || (NUM_SLICES < 1)) begin : g_bad_params
        $error("cla_seq_adder: OP_WIDTH must be a multiple of SLICE_WIDTH and SLICE_WIDTH a multiple of 4");
    end

    cla_seq_state_t state_q, state_d;
    logic [IDX_W-1:0]                         idx_q, idx_d;
    logic                                     carry_q, carry_d;
    logic                                     cout_q, cout_d;
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0]   a_q, a_d;
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0]   b_q, b_d;
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0]   sum_q, sum_d;

    logic [SLICE_WIDTH-1:0] slice_sum;
    logic                   slice_cout;

    cla_adder #(
        .WIDTH      (SLICE_WIDTH),
        .BLOCK_SIZE (4)
    ) u_cla (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = in_a;
                    idx_d = '0;
`ifdef CLA_SEQ_SUB_EN
                    // A - B computed as A + ~B + 1; in_cin is ignored when subtracting.
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_cin;
`else
                    b_d     = in_b;
                    carry_d = in_cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = slice_sum;
                carry_d      = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // idx stays on the last slice; only a new accept resets it.
                    cout_d  = slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule : cla_seq_adder

// File: tb/tb_cla_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_adder
//   Directed and random checks of cla_seq_adder at OP_WIDTH=128,
//   SLICE_WIDTH=32 against a plain-arithmetic reference model.
//   Define CLA_SEQ_SUB_EN to also exercise subtraction.
// ---------------------------------------------------------------------------
module tb_cla_seq_adder;

    localparam int unsigned OPW = 128;
    localparam int unsigned LAT = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_a;
    logic [OPW-1:0] in_b;
    logic           in_cin;
`ifdef CLA_SEQ_SUB_EN
    logic           in_sub;
`endif
    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] out_sum;
    logic           out_cout;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(
        .OP_WIDTH    (128),
        .SLICE_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef CLA_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    // Reference: {cout, sum} of the full-precision result.
    function automatic logic [OPW:0] ref_model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                               input logic cin, input logic sub);
        if (sub) begin
            return {((a >= b) ? 1'b1 : 1'b0), a - b};
        end
        return {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, cin};
    endfunction

    function automatic logic [OPW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input logic [OPW:0] obs, input logic [OPW:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, then scramble the inputs
    // so any late sampling of in_a/in_b/in_cin shows up as a wrong result.
    task automatic start_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                            input logic cin, input logic sub);
        int k;
        in_a   = a;
        in_b   = b;
        in_cin = cin;
`ifdef CLA_SEQ_SUB_EN
        in_sub = sub;
`endif
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk((OPW+1)'(in_ready), (OPW+1)'(1), "accept_ready");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = rnd128();
        in_b     = rnd128();
        in_cin   = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
        in_sub   = ~sub;
`endif
        chk((OPW+1)'(busy), (OPW+1)'(1), "busy_after_accept");
    endtask

    task automatic wait_result(input logic [OPW:0] exp, input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk((OPW+1)'(cyc), (OPW+1)'(LAT), {tag, "_latency"});
        chk({out_cout, out_sum}, exp, tag);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk((OPW+1)'({out_valid, in_ready}), (OPW+1)'(2'b01), "pop_to_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [OPW-1:0] a, b;
        logic [OPW:0]   e1, e2;
        logic           c, s;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        in_sub    = 1'b0;
`endif
        s = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk((OPW+1)'({in_ready, out_valid, busy}), (OPW+1)'(3'b100), "reset_flags");
        chk({out_cout, out_sum}, '0, "reset_result");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-ones + 1: full carry chain through every slice
        a = '1;
        start_op(a, 128'd1, 1'b0, 1'b0);
        wait_result({1'b1, {OPW{1'b0}}}, "allones_plus1");
        pop();

        // Carry crosses exactly two slice boundaries
        start_op({64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 128'd1, 1'b0, 1'b0);
        wait_result({1'b0, 128'h0000_0000_0000_0001_0000_0000_0000_0000}, "carry_two_slices");
        pop();

        // All-ones + 0 + cin
        start_op(a, 128'd0, 1'b1, 1'b0);
        wait_result(ref_model(a, 128'd0, 1'b1, 1'b0), "allones_cin");
        pop();

        // Random operands
        for (int i = 0; i < 12; i++) begin
            a = rnd128();
            b = rnd128();
            c = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
            s = 1'($urandom);
`endif
            start_op(a, b, c, s);
            wait_result(ref_model(a, b, c, s), "random_op");
            pop();
        end

        // Back-pressure in DONE with a second request pending
        a  = rnd128();
        b  = rnd128();
        e1 = ref_model(a, b, 1'b1, 1'b0);
        start_op(a, b, 1'b1, 1'b0);
        wait_result(e1, "bp_first");
        a  = rnd128();
        b  = rnd128();
        e2 = ref_model(a, b, 1'b0, 1'b0);
        in_a     = a;
        in_b     = b;
        in_cin   = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        in_sub   = 1'b0;
`endif
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk((OPW+1)'({out_valid, in_ready}), (OPW+1)'(2'b10), "bp_hold_flags");
            chk({out_cout, out_sum}, e1, "bp_hold_result");
        end
        pop();
        start_op(a, b, 1'b0, 1'b0);
        wait_result(e2, "bp_second");
        pop();

        // Reset pulse mid-RUN aborts the op
        start_op(rnd128(), rnd128(), 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk((OPW+1)'({in_ready, out_valid, busy}), (OPW+1)'(3'b100), "midrun_reset_flags");
        chk({out_cout, out_sum}, '0, "midrun_reset_result");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk((OPW+1)'({in_ready, out_valid}), (OPW+1)'(2'b10), "after_reset_idle");
        start_op(128'd3, 128'd4, 1'b0, 1'b0);
        wait_result({1'b0, 128'd7}, "after_reset_3p4");
        pop();

`ifdef CLA_SEQ_SUB_EN
        // Subtraction, in_cin ignored while in_sub=1
        start_op(128'd5, 128'd7, 1'b0, 1'b1);
        wait_result({1'b0, ~128'd1}, "sub_5m7");
        pop();
        start_op(128'd7, 128'd5, 1'b0, 1'b1);
        wait_result({1'b1, 128'd2}, "sub_7m5");
        pop();
        start_op(128'd9, 128'd9, 1'b0, 1'b1);
        wait_result({1'b1, 128'd0}, "sub_equal");
        pop();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cla_seq_adder
